multicycle_sequencer: RTL

Multi-cycle control sequencer for the 4-bit-opcode CPU datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states, and shares one instruction/data memory port between fetch and load/store. Each cycle it drives the per-step datapath strobes: PC/IR write, ALU operation and operand selects, register write, and memory request. It replaces single-cycle decode in the multi-cycle build and also keeps a retired-instruction count.

---
 rtl/multicycle_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
module multicycle_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_inc,
    output logic             pc_branch,
    output logic [3:0]       alu_op,
    output logic             alu_src,
    output logic             sign_ext,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_LW   = 4'b0111;
    localparam logic [3:0] OP_SW   = 4'b1000;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BLT  = 4'b1011;
    localparam logic [3:0] OP_BGT  = 4'b1100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [3:0]       op_q;
    logic [CNT_W-1:0] retired_q;

    logic is_branch;
    logic is_mem;
    logic is_legal;
    logic is_sext;
    logic retire;
    state_t after_last;

    always_comb begin
        is_branch = (op_q == OP_BEQ) || (op_q == OP_BNE) || (op_q == OP_BLT) || (op_q == OP_BGT);
        is_mem    = (op_q == OP_LW) || (op_q == OP_SW);
        is_legal  = is_branch || is_mem || (op_q == OP_R) || (op_q == OP_ADDI) || (op_q == OP_ORI);
        is_sext   = is_branch || is_mem || (op_q == OP_ADDI);
        after_last = run ? FETCH : IDLE;
    end

    // Retire happens in the final state of every legal instruction.
    always_comb begin
        retire = 1'b0;
        case (state)
            EXEC:    retire = is_branch;
            MEM:     retire = mem_ready && (op_q == OP_SW);
            WB:      retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= 4'b0000;
            retired_q <= '0;
        end else begin
            state <= next_state;
            if (ir_write) begin
                op_q <= op;
            end
            if (retire) begin
                retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = run ? FETCH : IDLE;
            FETCH:   next_state = mem_ready ? DECODE : FETCH;
            DECODE:  next_state = is_legal ? EXEC : after_last;
            EXEC: begin
                if (is_branch) begin
                    next_state = after_last;
                end else if (is_mem) begin
                    next_state = MEM;
                end else begin
                    next_state = WB;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    next_state = (op_q == OP_SW) ? after_last : WB;
                end
            end
            WB:      next_state = after_last;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_inc       = 1'b0;
        pc_branch    = 1'b0;
        alu_op       = 4'b0000;
        alu_src      = 1'b0;
        sign_ext     = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        illegal      = 1'b0;
        busy         = (state != IDLE);
        retired      = retired_q;
        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_inc   = mem_ready;
            end
            DECODE: begin
                illegal  = !is_legal;
                sign_ext = is_sext;
            end
            EXEC: begin
                alu_op    = op_q;
                alu_src   = !is_branch && (op_q != OP_R);
                pc_branch = is_branch;
                sign_ext  = is_sext;
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (op_q == OP_SW);
                alu_op       = op_q;
                sign_ext     = is_sext;
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op_q == OP_R);
                mem_to_reg = (op_q == OP_LW);
                sign_ext   = is_sext;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
